dmem_arbiter: RTL and testbench

- Shares the single data-memory port (dmem, SYNTH_MEM or BSRAM) between two requesters.
  - M0: the core data port.
  - M1: a secondary master, such as a program loader or debug/DMA engine.
- Arbitration is round-robin, with an optional M1 lock for bursts and a burst-length cap so the core is never starved.
- Sits in top between core/loader and dmem. It produces per-master grant (stall) and read-valid signals, and hides the memory read latency.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_rsp_pipe.sv | 44 ++++
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner tags and the
// {valid, owner} record carried down the read-latency pipe.
package dmem_arb_pkg;

  typedef enum logic [1:0] {ARB, LOCK1, YIELD} arb_state_t;

  typedef enum logic {OWN_M0, OWN_M1} owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rsp_slot_t;

  // Wide enough for the full legal burst cap of 255.
  localparam int BURST_CNT_W = 8;

  localparam rsp_slot_t RSP_EMPTY = '{valid: 1'b0, owner: OWN_M0};

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rsp_pipe.sv
// Delay line that tracks which master a read belongs to until the memory
// returns its data; collapses to a wire for an asynchronous memory.
module dmem_arbiter_rsp_pipe
  import dmem_arb_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_own,
  output logic out_vld,
  output logic out_own
);

  if (READ_LAT == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_vld        = in_vld;
    assign out_own        = in_own;
  end else begin : g_pipe
    rsp_slot_t pipe_q [READ_LAT];
    rsp_slot_t pipe_d [READ_LAT];

    always_comb begin
      pipe_d[0].valid = in_vld;
      pipe_d[0].owner = owner_t'(in_own);
      for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Reset empties every slot so no response survives a reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= RSP_EMPTY;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign out_vld = pipe_q[READ_LAT-1].valid;
    assign out_own = (pipe_q[READ_LAT-1].owner == OWN_M1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: round-robin with an
// optional M1 burst lock, capped so the core always gets a slot.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);

  arb_state_t             state_q, state_d;
  owner_t                 last_q, last_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d, burst_inc;
  logic                   rr_m0, rr_m1;
  logic                   gnt_m0, gnt_m1;
  logic [ADDR_W-1:0]      addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]      wdata_hold_q, wdata_hold_d;
  logic [DATA_W-1:0]      m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                   iss_vld, iss_own, ret_vld, ret_own;

  assign rr_m0     = m0_req & (~m1_req | (other_owner(last_q) == OWN_M0));
  assign rr_m1     = m1_req & (~m0_req | (other_owner(last_q) == OWN_M1));
  assign burst_inc = burst_q + BURST_CNT_W'(1);

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gnt_m0  = 1'b0;
    gnt_m1  = 1'b0;
    case (state_q)
      ARB: begin
        gnt_m0  = rr_m0;
        gnt_m1  = rr_m1;
        burst_d = '0;
        if (rr_m1 && m1_lock) begin
          burst_d = BURST_CNT_W'(1);
          state_d = (m0_req && BURST_LIM <= BURST_CNT_W'(1)) ? YIELD : LOCK1;
        end
      end
      LOCK1: begin
        if (!m1_lock) begin
          gnt_m0  = rr_m0;
          gnt_m1  = rr_m1;
          burst_d = '0;
          state_d = ARB;
        end else if (m1_req) begin
          gnt_m1  = 1'b1;
          burst_d = m0_req ? burst_inc : '0;
          if (m0_req && burst_inc >= BURST_LIM) state_d = YIELD;
        end else begin
          // M1 idle inside its lock: let the core use the free slot.
          gnt_m0 = m0_req;
          if (!m0_req) burst_d = '0;
        end
      end
      YIELD: begin
        gnt_m0  = m0_req;
        burst_d = '0;
        state_d = m1_lock ? LOCK1 : ARB;
      end
      default: begin
        burst_d = '0;
        state_d = ARB;
      end
    endcase
    if (rst) begin
      gnt_m0 = 1'b0;
      gnt_m1 = 1'b0;
    end
  end

  assign last_d = gnt_m0 ? OWN_M0 : (gnt_m1 ? OWN_M1 : last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      last_q  <= OWN_M1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Outputs are forced to zero while rst is high; the hold registers then
  // capture those zeros, so they need no reset of their own.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    if (gnt_m0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt_m1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign addr_hold_d  = mem_addr;
  assign wdata_hold_d = mem_wdata;
  assign iss_vld      = (gnt_m0 & ~m0_we) | (gnt_m1 & ~m1_we);
  assign iss_own      = gnt_m1;

  dmem_arbiter_rsp_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (iss_vld),
    .in_own  (iss_own),
    .out_vld (ret_vld),
    .out_own (ret_own)
  );

  assign m0_rvalid = ~rst & ret_vld & ~ret_own;
  assign m1_rvalid = ~rst & ret_vld & ret_own;

  always_comb begin
    m0_rdata_d = m0_rvalid ? mem_rdata : m0_rdata_q;
    m1_rdata_d = m1_rvalid ? mem_rdata : m1_rdata_q;
    if (rst) begin
      m0_rdata_d = '0;
      m1_rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    addr_hold_q  <= addr_hold_d;
    wdata_hold_q <= wdata_hold_d;
    m0_rdata_q   <= m0_rdata_d;
    m1_rdata_q   <= m1_rdata_d;
  end

  assign m0_gnt   = gnt_m0;
  assign m1_gnt   = gnt_m1;
  assign m0_rdata = m0_rdata_d;
  assign m1_rdata = m1_rdata_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a registered-memory build and an asynchronous-memory
// build share the same masters and are both compared against one cycle model.
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a, mem_we_a;
  logic [DW-1:0] m0_rdata_a, m1_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [AW-1:0] mem_addr_a;
  logic          m0_gnt_z, m0_rvalid_z, m1_gnt_z, m1_rvalid_z, mem_we_z;
  logic [DW-1:0] m0_rdata_z, m1_rdata_z, mem_wdata_z, mem_rdata_z;
  logic [AW-1:0] mem_addr_z;

  logic [DW-1:0] mem_a  [256];
  logic [DW-1:0] mem_z  [256];
  logic [DW-1:0] refmem [256];

  int n_total = 0;
  int n_pass  = 0;

  initial forever #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .BURST_MAX(BMAX)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(0), .BURST_MAX(BMAX)) dut_z (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_z), .m0_rvalid(m0_rvalid_z), .m0_rdata(m0_rdata_z),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt_z), .m1_rvalid(m1_rvalid_z), .m1_rdata(m1_rdata_z),
    .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
    .mem_rdata(mem_rdata_z)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i]  = init_word(i);
      mem_z[i]  = init_word(i);
      refmem[i] = init_word(i);
    end
  end

  // Memories: BSRAM-like (registered read) and SYNTH_MEM-like (async read)
  always @(posedge clk) begin
    mem_rdata_a <= mem_a[mem_addr_a[7:0]];
    if (mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    if (mem_we_z) mem_z[mem_addr_z[7:0]] <= mem_wdata_z;
  end
  assign mem_rdata_z = mem_z[mem_addr_z[7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
  endtask

  // Model state: mode 0 = free round-robin, 1 = M1 locked, 2 = core's turn
  int            mode      = 0;
  int            burst     = 0;
  logic          prefer_m0 = 1'b1;
  logic          prv_v     = 1'b0;
  logic          prv_own   = 1'b0;
  logic [31:0]   prv_data  = '0;
  logic [31:0]   hold_a0 = '0, hold_a1 = '0, hold_z0 = '0, hold_z1 = '0;
  logic [31:0]   held_addr = '0, held_wdata = '0;
  logic          last_g0 = 1'b0, last_g1 = 1'b0;

  always @(negedge clk) begin : model
    logic        g0, g1, x_we, rd, own, v_a0, v_a1, v_z0, v_z1;
    logic [31:0] x_addr, x_wdata, rdat;
    int          nmode, nburst;
    g0 = 1'b0; g1 = 1'b0; nmode = mode; nburst = burst;
    if (!rst) begin
      if (mode == 2) begin
        g0 = m0_req;
        nmode = m1_lock ? 1 : 0;
        nburst = 0;
      end else if (mode == 1 && m1_lock) begin
        if (m1_req) begin
          g1 = 1'b1;
          nburst = m0_req ? burst + 1 : 0;
          if (m0_req && nburst >= BMAX) nmode = 2;
        end else begin
          g0 = m0_req;
          if (!m0_req) nburst = 0;
        end
      end else begin
        if (m0_req && m1_req) begin
          g0 = prefer_m0;
          g1 = !prefer_m0;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
        nmode = 0; nburst = 0;
        if (g1 && m1_lock) begin
          nmode = (m0_req && BMAX <= 1) ? 2 : 1;
          nburst = 1;
        end
      end
    end
    x_we = 1'b0; x_addr = held_addr; x_wdata = held_wdata;
    if (g0) begin x_we = m0_we; x_addr = m0_addr; x_wdata = m0_wdata; end
    if (g1) begin x_we = m1_we; x_addr = m1_addr; x_wdata = m1_wdata; end
    if (rst) begin x_addr = '0; x_wdata = '0; end
    rd   = (g0 | g1) & !x_we;
    own  = g1;
    rdat = refmem[x_addr[7:0]];
    v_z0 = rd & !own;
    v_z1 = rd & own;
    v_a0 = !rst & prv_v & !prv_own;
    v_a1 = !rst & prv_v & prv_own;
    if (v_z0) hold_z0 = rdat;
    if (v_z1) hold_z1 = rdat;
    if (v_a0) hold_a0 = prv_data;
    if (v_a1) hold_a1 = prv_data;
    if (rst) begin hold_a0 = '0; hold_a1 = '0; hold_z0 = '0; hold_z1 = '0; end

    chk("a_m0_gnt", m0_gnt_a, g0);        chk("z_m0_gnt", m0_gnt_z, g0);
    chk("a_m1_gnt", m1_gnt_a, g1);        chk("z_m1_gnt", m1_gnt_z, g1);
    chk("a_mem_we", mem_we_a, x_we);      chk("z_mem_we", mem_we_z, x_we);
    chk("a_mem_addr", mem_addr_a, x_addr);   chk("z_mem_addr", mem_addr_z, x_addr);
    chk("a_mem_wdata", mem_wdata_a, x_wdata); chk("z_mem_wdata", mem_wdata_z, x_wdata);
    chk("a_m0_rvalid", m0_rvalid_a, v_a0); chk("z_m0_rvalid", m0_rvalid_z, v_z0);
    chk("a_m1_rvalid", m1_rvalid_a, v_a1); chk("z_m1_rvalid", m1_rvalid_z, v_z1);
    chk("a_m0_rdata", m0_rdata_a, hold_a0); chk("z_m0_rdata", m0_rdata_z, hold_z0);
    chk("a_m1_rdata", m1_rdata_a, hold_a1); chk("z_m1_rdata", m1_rdata_z, hold_z1);

    if (x_we) refmem[x_addr[7:0]] = x_wdata;
    prv_v = rd; prv_own = own; prv_data = rdat;
    held_addr = x_addr; held_wdata = x_wdata;
    if (rst) begin
      mode = 0; burst = 0; prefer_m0 = 1'b1;
    end else begin
      mode = nmode; burst = nburst;
      if (g0) prefer_m0 = 1'b0;
      if (g1) prefer_m0 = 1'b1;
    end
    last_g0 = g0; last_g1 = g1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int run, maxrun, p0, p1;
    rst = 1'b1; m1_lock = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14; m1_wdata = '0;
    tick();
    #2;
    chk("rst_m0_gnt", m0_gnt_a, 0);
    chk("rst_m1_gnt", m1_gnt_a, 0);
    chk("rst_mem_we", mem_we_a, 0);
    chk("rst_m0_rdata", m0_rdata_a, 0);
    tick();

    // Lone M0 read of 0x10
    rst = 1'b0; m1_req = 1'b0;
    #2;
    chk("rd10_m0_gnt", m0_gnt_a, 1);
    chk("rd10_mem_addr", mem_addr_a, 32'h10);
    chk("rd10_lat0_rvalid", m0_rvalid_z, 1);
    chk("rd10_lat0_rdata", m0_rdata_z, 32'hDEADBEEF);
    tick();
    m0_req = 1'b0;
    #2;
    chk("rd10_m0_rvalid", m0_rvalid_a, 1);
    chk("rd10_m0_rdata", m0_rdata_a, 32'hDEADBEEF);
    chk("rd10_m1_rvalid", m1_rvalid_a, 0);
    tick();

    // Both reading every cycle: strict alternation, M1 first (M0 won last)
    m0_req = 1'b1; m0_addr = 32'h30; m1_req = 1'b1; m1_addr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("rr_m0_gnt", m0_gnt_a, (i % 2) == 1);
      chk("rr_m1_gnt", m1_gnt_a, (i % 2) == 0);
      chk("rr_m1_rvalid", m1_rvalid_a, (i % 2) == 1);
      chk("rr_m0_rvalid", m0_rvalid_a, (i > 0) && ((i % 2) == 0));
      tick();
    end

    // M1 lock against a permanently requesting core
    m1_lock = 1'b1; run = 0; maxrun = 0;
    for (int i = 0; i < 15; i++) begin
      #2;
      chk("lock_m0_gnt", m0_gnt_a, (i % 5) == 4);
      chk("lock_m1_gnt", m1_gnt_a, (i % 5) != 4);
      if (m0_gnt_a) run = 0;
      else run++;
      if (run > maxrun) maxrun = run;
      tick();
    end
    chk("lock_max_low_run", maxrun <= 4, 1);
    m1_lock = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // M1 writes 0x55 to 0x20, M0 reads it back
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55;
    #2;
    chk("wr_m1_gnt", m1_gnt_a, 1);
    chk("wr_mem_we", mem_we_a, 1);
    chk("wr_mem_addr", mem_addr_a, 32'h20);
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    #2;
    chk("rb_m0_gnt", m0_gnt_a, 1);
    chk("rb_mem_we", mem_we_a, 0);
    chk("rb_lat0_rdata", m0_rdata_z, 32'h55);
    tick();
    m0_req = 1'b0;
    #2;
    chk("rb_m0_rvalid", m0_rvalid_a, 1);
    chk("rb_m0_rdata", m0_rdata_a, 32'h55);
    tick();

    // Reset right after a granted read drops the response
    m0_req = 1'b1; m0_addr = 32'h10;
    #2;
    chk("rr_pre_m0_gnt", m0_gnt_a, 1);
    tick();
    rst = 1'b1;
    #2;
    chk("mid_rst_m0_rvalid", m0_rvalid_a, 0);
    chk("mid_rst_m0_rdata", m0_rdata_a, 0);
    chk("mid_rst_m0_gnt", m0_gnt_a, 0);
    chk("mid_rst_mem_we", mem_we_a, 0);
    chk("mid_rst_mem_addr", mem_addr_a, 0);
    tick();
    rst = 1'b0; m0_req = 1'b0;
    #2;
    chk("post_rst_m0_rvalid", m0_rvalid_a, 0);
    tick();

    // Randomised traffic; masters hold their request until granted
    for (int c = 0; c < 2500; c++) begin
      p0 = ((c / 500) % 2 == 1) ? 90 : 50;
      p1 = ((c / 300) % 2 == 1) ? 85 : 40;
      rst = ($urandom_range(0, 199) == 0);
      if (last_g0 || !m0_req) begin
        m0_req   = ($urandom_range(0, 99) < p0);
        m0_we    = ($urandom_range(0, 2) == 0);
        m0_addr  = 32'($urandom_range(0, 255));
        m0_wdata = $urandom;
      end
      if (last_g1 || !m1_req) begin
        m1_req   = ($urandom_range(0, 99) < p1);
        m1_we    = ($urandom_range(0, 2) == 0);
        m1_addr  = 32'($urandom_range(0, 255));
        m1_wdata = $urandom;
      end
      if ($urandom_range(0, 19) == 0) m1_lock = ~m1_lock;
      tick();
    end
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
